nioslab2_ram_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single-port on-chip RAM (1024 x 32, byte-enabled, one access per clock) between two masters, for example the Nios II data master and a DMA/peripheral master. Each master sees its own pipelined slave port with waitrequest and readdatavalid. The block owns the RAM's address, byteenable, chipselect, write, writedata and clken inputs, and returns RAM readdata to the master that issued the read.

---
 rtl/nioslab2_ram_arbiter_if.sv | 28 ++
 rtl/nioslab2_ram_arbiter.sv | 110 +++++++++++
 tb/tb_nioslab2_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nioslab2_ram_arbiter_if.sv
// Avalon-MM slave-side bundle for one arbiter port: request signals in,
// waitrequest / read return out.
interface nioslab2_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    // Handshake: a request is accepted in any cycle where (read | write) is
    // high and waitrequest is low; readdatavalid pulses once per accepted read.
    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nioslab2_ram_arbiter.sv
// Two-master arbiter in front of a single-port byte-enabled RAM; grants one
// access per clock and routes read data back through a {valid, port} tag pipe.
module nioslab2_ram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int RD_LAT     = 1,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nioslab2_ram_arbiter_if.slave p0,
    nioslab2_ram_arbiter_if.slave p1,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [BE_W-1:0]       ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  dbg_last_grant_o,
    output logic [3:0]            dbg_starve_cnt_o
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              run_q;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] tag_v_q, tag_p_q;

    logic              req0, req1, gnt0, gnt1, busy, sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;

    always_comb begin
        req0 = p0.read | p0.write;
        req1 = p1.read | p1.write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // run_q keeps both ports stalled until the first edge after reset
        if (run_q) begin
            if (req0 && req1) begin
                if (ARB_MODE == 0) gnt1 = ~last_grant_q;
                else               gnt1 = (starve_cnt_q == STARVE_LIM);
                gnt0 = ~gnt1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        busy     = gnt0 | gnt1;
        sel_wr   = gnt1 ? p1.write      : p0.write;
        sel_addr = gnt1 ? p1.address    : p0.address;
        sel_be   = gnt1 ? p1.byteenable : p0.byteenable;
        sel_wd   = gnt1 ? p1.writedata  : p0.writedata;

        last_grant_d = last_grant_q;
        if (gnt0) last_grant_d = 1'b0;
        if (gnt1) last_grant_d = 1'b1;

        starve_cnt_d = starve_cnt_q;
        if (gnt1)              starve_cnt_d = 4'd0;
        else if (req1 && gnt0) starve_cnt_d = starve_cnt_q + 4'd1;

        addr_d = busy ? sel_addr : addr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q        <= 1'b0;
            last_grant_q <= 1'b1;
            starve_cnt_q <= 4'd0;
            addr_q       <= '0;
            tag_v_q      <= '0;
            tag_p_q      <= '0;
        end else begin
            run_q        <= 1'b1;
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_p_q[i] <= tag_p_q[i-1];
            end
            // read+write together is a write: no tag, no readdatavalid
            tag_v_q[0] <= busy & ~sel_wr;
            tag_p_q[0] <= gnt1;
        end
    end

    assign ram_chipselect = busy;
    assign ram_write      = busy & sel_wr;
    assign ram_address    = addr_d;
    assign ram_byteenable = (busy && sel_wr) ? sel_be : {BE_W{1'b1}};
    assign ram_writedata  = sel_wd;
    assign ram_clken      = run_q;

    assign p0.waitrequest   = ~gnt0;
    assign p1.waitrequest   = ~gnt1;
    assign p0.readdata      = ram_readdata;
    assign p1.readdata      = ram_readdata;
    assign p0.readdatavalid = tag_v_q[RD_LAT-1] & ~tag_p_q[RD_LAT-1];
    assign p1.readdatavalid = tag_v_q[RD_LAT-1] &  tag_p_q[RD_LAT-1];

    assign dbg_last_grant_o = last_grant_q;
    assign dbg_starve_cnt_o = starve_cnt_q;
endmodule

// File: tb/tb_nioslab2_ram_arbiter.sv
// Directed bench: round-robin instance against a RAM model (vector table),
// priority instance for starvation control, and a mid-read reset sequence.
module tb_nioslab2_ram_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic load_mem = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nioslab2_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) a0 ();
    nioslab2_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) a1 ();
    nioslab2_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) b0 ();
    nioslab2_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) b1 ();

    logic [9:0]  ram_addr_a, ram_addr_b;
    logic [3:0]  ram_be_a, ram_be_b;
    logic        ram_cs_a, ram_cs_b, ram_we_a, ram_we_b, ram_ck_a, ram_ck_b;
    logic [31:0] ram_wd_a, ram_wd_b, ram_rd_a;
    logic [31:0] ram_rd_b = 32'h0;
    logic        last_a, last_b;
    logic [3:0]  starve_a, starve_b;

    nioslab2_ram_arbiter #(.ARB_MODE(0)) dut_rr (
        .clk(clk), .reset_n(reset_n), .p0(a0), .p1(a1),
        .ram_address(ram_addr_a), .ram_byteenable(ram_be_a), .ram_chipselect(ram_cs_a),
        .ram_write(ram_we_a), .ram_writedata(ram_wd_a), .ram_clken(ram_ck_a),
        .ram_readdata(ram_rd_a), .dbg_last_grant_o(last_a), .dbg_starve_cnt_o(starve_a)
    );

    nioslab2_ram_arbiter #(.ARB_MODE(1), .STARVE_MAX(4)) dut_pr (
        .clk(clk), .reset_n(reset_n), .p0(b0), .p1(b1),
        .ram_address(ram_addr_b), .ram_byteenable(ram_be_b), .ram_chipselect(ram_cs_b),
        .ram_write(ram_we_b), .ram_writedata(ram_wd_b), .ram_clken(ram_ck_b),
        .ram_readdata(ram_rd_b), .dbg_last_grant_o(last_b), .dbg_starve_cnt_o(starve_b)
    );

    // RAM model, one-cycle read latency; preloaded with 0xC0DE0000 | address
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
        end else if (ram_ck_a && ram_cs_a) begin
            if (ram_we_a) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_a[b]) mem[ram_addr_a][b*8 +: 8] <= ram_wd_a[b*8 +: 8];
            end else begin
                ram_rd_a <= mem[ram_addr_a];
            end
        end
    end

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [9:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
    } pin_t;

    typedef struct {
        pin_t        q0;
        pin_t        q1;
        logic        w0;
        logic        w1;
        logic        cs;
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        v0;
        logic        v1;
        logic [31:0] rdata;
    } vec_t;

    function automatic pin_t p_idle();
        pin_t p;
        p = '0;
        return p;
    endfunction

    function automatic pin_t p_rd(input int a);
        pin_t p;
        p = '0;
        p.rd = 1'b1;
        p.a = 10'(a);
        p.be = 4'hF;
        return p;
    endfunction

    function automatic pin_t p_wr(input int a, input logic [3:0] be, input logic [31:0] wd);
        pin_t p;
        p = '0;
        p.wr = 1'b1;
        p.a = 10'(a);
        p.be = be;
        p.wd = wd;
        return p;
    endfunction

    function automatic pin_t p_rw(input int a, input logic [31:0] wd);
        pin_t p;
        p = p_wr(a, 4'hF, wd);
        p.rd = 1'b1;
        return p;
    endfunction

    task automatic drive_a(input pin_t q0, input pin_t q1);
        a0.read = q0.rd; a0.write = q0.wr; a0.address = q0.a;
        a0.byteenable = q0.be; a0.writedata = q0.wd;
        a1.read = q1.rd; a1.write = q1.wr; a1.address = q1.a;
        a1.byteenable = q1.be; a1.writedata = q1.wd;
    endtask

    task automatic drive_b(input pin_t q0, input pin_t q1);
        b0.read = q0.rd; b0.write = q0.wr; b0.address = q0.a;
        b0.byteenable = q0.be; b0.writedata = q0.wd;
        b1.read = q1.rd; b1.write = q1.wr; b1.address = q1.a;
        b1.byteenable = q1.be; b1.writedata = q1.wd;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk1({tag, "_wait0"}, a0.waitrequest, 1'b1);
        chk1({tag, "_wait1"}, a1.waitrequest, 1'b1);
        chk1({tag, "_cs"}, ram_cs_a, 1'b0);
        chk1({tag, "_we"}, ram_we_a, 1'b0);
        chk1({tag, "_clken"}, ram_ck_a, 1'b0);
        chk1({tag, "_rdv0"}, a0.readdatavalid, 1'b0);
        chk1({tag, "_rdv1"}, a1.readdatavalid, 1'b0);
        chk1({tag, "_last"}, last_a, 1'b1);
    endtask

    vec_t vecs [21];
    logic exp_g [10];
    logic [3:0] exp_s [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{p_idle(), p_idle(), 1, 1, 0, 0, 10'd0, 4'hF, 32'h0, 0, 0, 32'h0};
        vecs[1]  = '{p_wr(5, 4'hF, 32'hDEADBEEF), p_idle(), 0, 1, 1, 1, 10'd5, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0};
        vecs[2]  = '{p_rd(5), p_idle(), 0, 1, 1, 0, 10'd5, 4'hF, 32'h0, 0, 0, 32'h0};
        vecs[3]  = '{p_idle(), p_idle(), 1, 1, 0, 0, 10'd0, 4'hF, 32'h0, 1, 0, 32'hDEADBEEF};
        vecs[4]  = '{p_wr(9, 4'hF, 32'h11223344), p_idle(), 0, 1, 1, 1, 10'd9, 4'hF, 32'h11223344, 0, 0, 32'h0};
        vecs[5]  = '{p_wr(9, 4'b1000, 32'hAA000000), p_idle(), 0, 1, 1, 1, 10'd9, 4'b1000, 32'hAA000000, 0, 0, 32'h0};
        vecs[6]  = '{p_rd(9), p_idle(), 0, 1, 1, 0, 10'd9, 4'hF, 32'h0, 0, 0, 32'h0};
        vecs[7]  = '{p_idle(), p_idle(), 1, 1, 0, 0, 10'd0, 4'hF, 32'h0, 1, 0, 32'hAA223344};
        vecs[8]  = '{p_idle(), p_rw(3, 32'h5A5A5A5A), 1, 0, 1, 1, 10'd3, 4'hF, 32'h5A5A5A5A, 0, 0, 32'h0};
        vecs[9]  = '{p_idle(), p_rd(3), 1, 0, 1, 0, 10'd3, 4'hF, 32'h0, 0, 0, 32'h0};
        vecs[10] = '{p_idle(), p_idle(), 1, 1, 0, 0, 10'd0, 4'hF, 32'h0, 0, 1, 32'h5A5A5A5A};
        vecs[11] = '{p_rd(20), p_rd(40), 0, 1, 1, 0, 10'd20, 4'hF, 32'h0, 0, 0, 32'h0};
        vecs[12] = '{p_rd(21), p_rd(40), 1, 0, 1, 0, 10'd40, 4'hF, 32'h0, 1, 0, 32'hC0DE0014};
        vecs[13] = '{p_rd(21), p_rd(41), 0, 1, 1, 0, 10'd21, 4'hF, 32'h0, 0, 1, 32'hC0DE0028};
        vecs[14] = '{p_rd(22), p_rd(41), 1, 0, 1, 0, 10'd41, 4'hF, 32'h0, 1, 0, 32'hC0DE0015};
        vecs[15] = '{p_rd(22), p_rd(42), 0, 1, 1, 0, 10'd22, 4'hF, 32'h0, 0, 1, 32'hC0DE0029};
        vecs[16] = '{p_rd(23), p_rd(42), 1, 0, 1, 0, 10'd42, 4'hF, 32'h0, 1, 0, 32'hC0DE0016};
        vecs[17] = '{p_rd(23), p_rd(43), 0, 1, 1, 0, 10'd23, 4'hF, 32'h0, 0, 1, 32'hC0DE002A};
        vecs[18] = '{p_rd(24), p_rd(43), 1, 0, 1, 0, 10'd43, 4'hF, 32'h0, 1, 0, 32'hC0DE0017};
        vecs[19] = '{p_rd(24), p_idle(), 0, 1, 1, 0, 10'd24, 4'hF, 32'h0, 0, 1, 32'hC0DE002B};
        vecs[20] = '{p_idle(), p_idle(), 1, 1, 0, 0, 10'd0, 4'hF, 32'h0, 1, 0, 32'hC0DE0018};

        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

        // Reset state
        drive_a(p_idle(), p_idle());
        drive_b(p_idle(), p_idle());
        repeat (2) @(posedge clk);
        #1;
        chk_reset_a("rst");
        chk1("rst_pr_wait0", b0.waitrequest, 1'b1);
        chk32("rst_pr_starve", 32'(starve_b), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        load_mem = 1'b0;
        @(posedge clk);

        // Vector table against the round-robin instance
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive_a(vecs[i].q0, vecs[i].q1);
            #1;
            chk1($sformatf("v%0d_wait0", i), a0.waitrequest, vecs[i].w0);
            chk1($sformatf("v%0d_wait1", i), a1.waitrequest, vecs[i].w1);
            chk1($sformatf("v%0d_cs", i), ram_cs_a, vecs[i].cs);
            chk1($sformatf("v%0d_we", i), ram_we_a, vecs[i].we);
            chk1($sformatf("v%0d_rdv0", i), a0.readdatavalid, vecs[i].v0);
            chk1($sformatf("v%0d_rdv1", i), a1.readdatavalid, vecs[i].v1);
            if (vecs[i].cs) begin
                chk32($sformatf("v%0d_addr", i), 32'(ram_addr_a), 32'(vecs[i].addr));
                chk32($sformatf("v%0d_be", i), 32'(ram_be_a), 32'(vecs[i].be));
            end
            if (vecs[i].we) chk32($sformatf("v%0d_wd", i), ram_wd_a, vecs[i].wd);
            if (vecs[i].v0) chk32($sformatf("v%0d_rdata0", i), a0.readdata, vecs[i].rdata);
            if (vecs[i].v1) chk32($sformatf("v%0d_rdata1", i), a1.readdata, vecs[i].rdata);
        end
        chk1("clken_run", ram_ck_a, 1'b1);
        chk32("mem3_rw", mem[3], 32'h5A5A5A5A);

        // Priority instance: both ports request continuously
        @(negedge clk);
        drive_a(p_idle(), p_idle());
        drive_b(p_rd(7), p_rd(8));
        for (int i = 0; i < 10; i++) begin
            logic prev_g;
            prev_g = (i > 0) ? exp_g[i-1] : 1'b0;
            #1;
            chk1($sformatf("pr%0d_wait0", i), b0.waitrequest, exp_g[i]);
            chk1($sformatf("pr%0d_wait1", i), b1.waitrequest, ~exp_g[i]);
            chk32($sformatf("pr%0d_starve", i), 32'(starve_b), 32'(exp_s[i]));
            chk1($sformatf("pr%0d_rdv1", i), b1.readdatavalid, prev_g);
            if (i > 0) chk1($sformatf("pr%0d_rdv0", i), b0.readdatavalid, ~prev_g);
            @(negedge clk);
        end
        drive_b(p_idle(), p_idle());

        // Reset while a p0 read is in flight
        drive_a(p_rd(5), p_idle());
        #1;
        chk1("mr_accept", a0.waitrequest, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_a("mr_in");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_reset_a($sformatf("mr_hold%0d", i));
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive_a(p_idle(), p_idle());
        #1;
        chk1("mr_rel_rdv0", a0.readdatavalid, 1'b0);
        @(negedge clk);
        #1;
        chk1("mr_post_rdv0", a0.readdatavalid, 1'b0);
        chk1("mr_post_rdv1", a1.readdatavalid, 1'b0);
        chk1("mr_post_clken", ram_ck_a, 1'b1);
        drive_a(p_rd(5), p_idle());
        #1;
        chk1("mr_new_wait0", a0.waitrequest, 1'b0);
        chk1("mr_new_cs", ram_cs_a, 1'b1);
        chk32("mr_new_addr", 32'(ram_addr_a), 32'd5);
        @(negedge clk);
        drive_a(p_idle(), p_idle());
        #1;
        chk1("mr_new_rdv0", a0.readdatavalid, 1'b1);
        chk32("mr_new_rdata", a0.readdata, 32'hDEADBEEF);
        chk1("mr_new_rdv1", a1.readdatavalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
